alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

- Issuing side of the 16-bit serial ALU datapath interface.
- Accepts one 32-bit ALU operation per valid/ready handshake and splits it into half-word beats with the correct `first_cycle` framing and half ordering.
- Collects the two 16-bit result halves, or the compare result, into a registered 32-bit response held under backpressure.
- Sits between the execute-stage control and the serial ALU; it is the only driver of the ALU's control and operand inputs.

## Interface
Parameters:
- `XLEN`, 32: architectural operand width; two ALU beats of `XLEN/2`.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous reset, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: sequencer can accept a request.
- `in_op` input `cs_alu_op`: operation (typedefs package).
- `in_cmp_flip` input 1: invert compare sense.
- `in_a`, `in_b` input 32: operands.
- `alu_op_o` output `cs_alu_op`: ALU operation.
- `alu_cmp_flip_o` output 1: ALU compare inversion.
- `alu_first_cycle_o` output 1: marks the first beat.
- `alu_a_o`, `alu_b_o` output 16: beat operands.
- `alu_result_i` input 16: beat result.
- `alu_cmp_result_i` input 1: compare outcome.
- `alu_cmp_result_valid_i` input 1: compare outcome is final.
- `out_valid` output 1: response present.
- `out_ready` input 1: consumer accepts the response.
- `out_result` output 32: operation result; for compares, `{31'b0, cmp}`.
- `busy` output 1: state is not IDLE.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: `in_ready=1`. On `in_valid`, register op, flip, a and b, then go to BEAT0.
- BEAT0: `alu_first_cycle_o=1` and the first half is driven. Go to BEAT1, or to DONE on EQ early exit.
- BEAT1: the second half is driven. `alu_first_cycle_o=0`, except for shift re-issue. Go to DONE.
- DONE: `out_valid=1`. Leave for IDLE on `out_ready`. All outputs are held stable while stalled.
- `alu_op_o` and `alu_cmp_flip_o` are driven from the registered request during BEAT0 and BEAT1. In IDLE and DONE they drive `ALU_OP_ADD`, 0, and operands are 0.

Half ordering (`b_o` always carries the matching half of b, except for shifts):
- ADD, SUB, PLUS_4, AND, OR, XOR, LT, LTU, EQ: low half in BEAT0, high half in BEAT1.
- SRL, SRA: BEAT0 drives `a[31:16]` and returns the high result; BEAT1 drives `a[15:0]` and returns the low result.
- SLL: BEAT0 drives `a[15:0]` and returns the low result; BEAT1 drives `a[31:16]` and returns the high result.
- Shifts: `alu_b_o = {11'b0, b[4:0]}` in BEAT0.

Shift re-issue when `b[4]=1`:
- BEAT1 keeps `alu_first_cycle_o=1` and clears `alu_b_o[4]`.
- BEAT1 drives the same a half that was driven in BEAT0.
- Result for SRL: high=0, low=`a_hi>>s`.
- Result for SRA: high=sign fill, low=`a_hi>>>s`.
- Result for SLL: low=0, high=`a_lo<<s`.
- Here `s=b[3:0]`.

Compares:
- The compare bit is captured from `alu_cmp_result_i` in the beat where `alu_cmp_result_valid_i=1`.
- LT/LTU: capture in BEAT1.
- EQ: see Configuration.

Width and arithmetic:
- Carry propagation is internal to the ALU.
- The sequencer only guarantees BEAT0 immediately precedes BEAT1 with no idle cycle between them.

Reset:
- State returns to IDLE.
- `out_valid=0`, `out_result=0`, `busy=0`, `in_ready=0` during reset and 1 from the first cycle after.
- `alu_first_cycle_o=0`.
- Reset mid-operation discards the request; no response is produced.

## Timing
- Request accepted at edge N: BEAT0 runs in cycle N+1, BEAT1 in N+2, `out_valid` rises in N+3.
- Full operation latency is 3 cycles. EQ early exit takes 2 cycles.
- Throughput: one operation per 4 cycles when `out_ready=1`.
- `in_ready` is asserted only in IDLE. No new request is accepted in the same cycle a response retires.
- Results are registered at the end of each beat; there is no combinational path from `alu_result_i` to `out_result`.
- `in_valid` asserted during reset is ignored.

## Configuration
- `ALU_SEQ_EQ_EARLY_EXIT_EN` defined:
  - EQ with `alu_cmp_result_valid_i=1` in BEAT0 (low halves differ) goes straight to DONE with the BEAT0 compare result.
  - Otherwise BEAT1 runs and the result is captured there.
- `ALU_SEQ_EQ_EARLY_EXIT_EN` undefined:
  - EQ always runs BEAT1.
  - The compare bit is captured in BEAT1 regardless of the BEAT0 valid.

## Test plan
- ADD a=0x0001FFFF, b=0x00000001: beats show first_cycle 1 then 0, with a_o 0xFFFF then 0x0001. Response `out_result=0x00020000` at N+3.
- SRL a=0x80000000, b=4: BEAT0 a_o=0x8000, BEAT1 a_o=0x0000. Response 0x08000000.
- SRA a=0x80000000, b=20: BEAT1 shows first_cycle=1 and b_o=0x0004. Response 0xFFFFF800.
- EQ a=0x00010002, b=0x00010003 with macro defined: response `out_result=0` after 2 cycles and no BEAT1. With the macro undefined, the same response arrives after 3 cycles.
- LTU a=0x00000001, b=0xFFFFFFFF: `out_result=1`. Holding `out_ready=0` for 5 cycles keeps out_valid/out_result stable and `in_ready=0`.
- Assert `rst` during BEAT1: next cycle state is IDLE with `out_valid=0`, `busy=0`, `in_ready=0`; `in_ready=1` once `rst` is released. A new request afterwards completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issuing side of the 16-bit serial ALU: splits one 32-bit operation into two beats and assembles the response.
// Optional: define ALU_SEQ_EQ_EARLY_EXIT_EN to let EQ finish after BEAT0 when the low halves already differ.

package alu_seq_pkg;
    typedef enum logic [3:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_PLUS_4,
        ALU_OP_AND,
        ALU_OP_OR,
        ALU_OP_XOR,
        ALU_OP_LT,
        ALU_OP_LTU,
        ALU_OP_EQ,
        ALU_OP_SRL,
        ALU_OP_SRA,
        ALU_OP_SLL
    } cs_alu_op;
endpackage

// state | meaning
// IDLE  | waiting for a request, in_ready high
// BEAT0 | first half issued, first_cycle high
// BEAT1 | second half (or shift re-issue) issued
// DONE  | response held until out_ready
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  cs_alu_op          in_op,
    input  logic              in_cmp_flip,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    output cs_alu_op          alu_op_o,
    output logic              alu_cmp_flip_o,
    output logic              alu_first_cycle_o,
    output logic [XLEN/2-1:0] alu_a_o,
    output logic [XLEN/2-1:0] alu_b_o,
    input  logic [XLEN/2-1:0] alu_result_i,
    input  logic              alu_cmp_result_i,
    input  logic              alu_cmp_result_valid_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              busy
);
    localparam int H = XLEN / 2;

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_DONE} state_t;

    state_t          state_q, state_d;
    cs_alu_op        op_q;
    logic            flip_q;
    logic [XLEN-1:0] a_q, b_q, res_q;
    logic            is_shift, is_right, is_cmp, reissue, early_exit;
    logic [H-1:0]    a_lo, a_hi, shamt0, shamt1;

    assign a_lo     = a_q[H-1:0];
    assign a_hi     = a_q[XLEN-1:H];
    assign is_right = (op_q == ALU_OP_SRL) || (op_q == ALU_OP_SRA);
    assign is_shift = is_right || (op_q == ALU_OP_SLL);
    assign is_cmp   = (op_q == ALU_OP_LT) || (op_q == ALU_OP_LTU) || (op_q == ALU_OP_EQ);
    assign reissue  = is_shift && b_q[4];
    // Re-issue beat shifts by the residual amount; bit 4 was consumed by moving the half.
    assign shamt0   = {{(H-5){1'b0}}, b_q[4:0]};
    assign shamt1   = {{(H-5){1'b0}}, 1'b0, b_q[3:0]};

`ifdef ALU_SEQ_EQ_EARLY_EXIT_EN
    assign early_exit = (state_q == S_BEAT0) && (op_q == ALU_OP_EQ) && alu_cmp_result_valid_i;
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        alu_op_o          = ALU_OP_ADD;
        alu_cmp_flip_o    = 1'b0;
        alu_first_cycle_o = 1'b0;
        alu_a_o           = '0;
        alu_b_o           = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = S_BEAT0;
            end
            S_BEAT0: begin
                alu_op_o          = op_q;
                alu_cmp_flip_o    = flip_q;
                alu_first_cycle_o = 1'b1;
                if (is_shift) begin
                    alu_a_o = is_right ? a_hi : a_lo;
                    alu_b_o = shamt0;
                end else begin
                    alu_a_o = a_lo;
                    alu_b_o = b_q[H-1:0];
                end
                state_d = early_exit ? S_DONE : S_BEAT1;
            end
            S_BEAT1: begin
                alu_op_o       = op_q;
                alu_cmp_flip_o = flip_q;
                if (is_shift) begin
                    alu_b_o = shamt1;
                    if (reissue) begin
                        alu_first_cycle_o = 1'b1;
                        alu_a_o           = is_right ? a_hi : a_lo;
                    end else begin
                        alu_a_o = is_right ? a_lo : a_hi;
                    end
                end else begin
                    alu_a_o = a_hi;
                    alu_b_o = b_q[XLEN-1:H];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= ALU_OP_ADD;
            flip_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= in_op;
                        flip_q <= in_cmp_flip;
                        a_q    <= in_a;
                        b_q    <= in_b;
                        res_q  <= '0;
                    end
                end
                S_BEAT0: begin
                    if (early_exit) begin
                        res_q <= {{(XLEN-1){1'b0}}, alu_cmp_result_i};
                    end else if (!is_cmp) begin
                        if (is_right) res_q[XLEN-1:H] <= alu_result_i;
                        else          res_q[H-1:0]    <= alu_result_i;
                    end
                end
                S_BEAT1: begin
                    if (is_cmp) begin
                        if (alu_cmp_result_valid_i)
                            res_q <= {{(XLEN-1){1'b0}}, alu_cmp_result_i};
                    end else if (reissue) begin
                        // The half shifted out entirely is zero (or sign fill) without asking the ALU.
                        if (op_q == ALU_OP_SRL)      res_q <= {{H{1'b0}}, alu_result_i};
                        else if (op_q == ALU_OP_SRA) res_q <= {{H{a_q[XLEN-1]}}, alu_result_i};
                        else                         res_q <= {alu_result_i, {H{1'b0}}};
                    end else if (is_right) begin
                        res_q[H-1:0] <= alu_result_i;
                    end else begin
                        res_q[XLEN-1:H] <= alu_result_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_result = res_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: stands in for the serial ALU with hand-computed beat results.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_EQ_EARLY_EXIT_EN
    localparam bit EQ_EARLY = 1'b1;
`else
    localparam bit EQ_EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    cs_alu_op    in_op;
    logic        in_cmp_flip;
    logic [31:0] in_a, in_b;
    cs_alu_op    alu_op_o;
    logic        alu_cmp_flip_o;
    logic        alu_first_cycle_o;
    logic [15:0] alu_a_o, alu_b_o;
    logic [15:0] alu_result_i;
    logic        alu_cmp_result_i;
    logic        alu_cmp_result_valid_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(.XLEN(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_op                  (in_op),
        .in_cmp_flip            (in_cmp_flip),
        .in_a                   (in_a),
        .in_b                   (in_b),
        .alu_op_o               (alu_op_o),
        .alu_cmp_flip_o         (alu_cmp_flip_o),
        .alu_first_cycle_o      (alu_first_cycle_o),
        .alu_a_o                (alu_a_o),
        .alu_b_o                (alu_b_o),
        .alu_result_i           (alu_result_i),
        .alu_cmp_result_i       (alu_cmp_result_i),
        .alu_cmp_result_valid_i (alu_cmp_result_valid_i),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_result             (out_result),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered and left just after a falling edge with the DUT in IDLE.
    task automatic do_op(input string tag, input cs_alu_op op, input logic flip,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] r0, input logic c0, input logic v0,
                         input logic [15:0] r1, input logic c1, input logic v1,
                         input logic [15:0] ea0, input logic [15:0] eb0,
                         input logic [15:0] ea1, input logic [15:0] eb1,
                         input logic ef1, input logic chk_b1, input logic early,
                         input int hold, input logic [31:0] exp_res);
        in_op = op; in_cmp_flip = flip; in_a = a; in_b = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_result_i = r0; alu_cmp_result_i = c0; alu_cmp_result_valid_i = v0;
        @(negedge clk);
        chk({tag, ".b0.first"}, 32'(alu_first_cycle_o), 32'd1);
        chk({tag, ".b0.a"}, 32'(alu_a_o), 32'(ea0));
        chk({tag, ".b0.b"}, 32'(alu_b_o), 32'(eb0));
        chk({tag, ".b0.op"}, 32'(alu_op_o), 32'(op));
        chk({tag, ".b0.flip"}, 32'(alu_cmp_flip_o), 32'(flip));
        chk({tag, ".b0.busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        if (!early) begin
            alu_result_i = r1; alu_cmp_result_i = c1; alu_cmp_result_valid_i = v1;
            @(negedge clk);
            chk({tag, ".b1.first"}, 32'(alu_first_cycle_o), 32'(ef1));
            chk({tag, ".b1.a"}, 32'(alu_a_o), 32'(ea1));
            if (chk_b1) chk({tag, ".b1.b"}, 32'(alu_b_o), 32'(eb1));
            chk({tag, ".b1.ovalid"}, 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        alu_result_i = 16'h0; alu_cmp_result_i = 1'b0; alu_cmp_result_valid_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".stall.ovalid"}, 32'(out_valid), 32'd1);
            chk({tag, ".stall.result"}, out_result, exp_res);
            chk({tag, ".stall.in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".done.ovalid"}, 32'(out_valid), 32'd1);
        chk({tag, ".done.result"}, out_result, exp_res);
        chk({tag, ".done.in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".done.op"}, 32'(alu_op_o), 32'(ALU_OP_ADD));
        chk({tag, ".done.a"}, 32'(alu_a_o), 32'd0);
        chk({tag, ".done.first"}, 32'(alu_first_cycle_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".idle.ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle.in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_op = ALU_OP_ADD; in_cmp_flip = 1'b0;
        in_a = 32'h0; in_b = 32'h0; out_ready = 1'b1;
        alu_result_i = 16'h0; alu_cmp_result_i = 1'b0; alu_cmp_result_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ovalid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.result", out_result, 32'h0);
        chk("rst.first", 32'(alu_first_cycle_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);
        chk("post_rst.busy", 32'(busy), 32'd0);

        //     tag     op          fl  a             b             r0      c0 v0  r1      c1 v1  ea0     eb0     ea1     eb1     ef1 cb1 early     hold exp
        do_op("add",   ALU_OP_ADD, 0, 32'h0001FFFF, 32'h00000001, 16'h0000,0,0, 16'h0002,0,0, 16'hFFFF,16'h0001,16'h0001,16'h0000,0, 1, 1'b0,     0, 32'h00020000);
        do_op("srl",   ALU_OP_SRL, 0, 32'h80000000, 32'h00000004, 16'h0800,0,0, 16'h0000,0,0, 16'h8000,16'h0004,16'h0000,16'h0000,0, 0, 1'b0,     0, 32'h08000000);
        do_op("sra20", ALU_OP_SRA, 0, 32'h80000000, 32'h00000014, 16'hFFFF,0,0, 16'hF800,0,0, 16'h8000,16'h0014,16'h8000,16'h0004,1, 1, 1'b0,     0, 32'hFFFFF800);
        do_op("sll17", ALU_OP_SLL, 0, 32'h00000003, 32'h00000011, 16'h0000,0,0, 16'h0006,0,0, 16'h0003,16'h0011,16'h0003,16'h0001,1, 1, 1'b0,     0, 32'h00060000);
        do_op("sll1",  ALU_OP_SLL, 0, 32'h00018001, 32'h00000001, 16'h0002,0,0, 16'h0003,0,0, 16'h8001,16'h0001,16'h0001,16'h0000,0, 0, 1'b0,     0, 32'h00030002);
        do_op("eq_ne", ALU_OP_EQ,  0, 32'h00010002, 32'h00010003, 16'h0000,0,1, 16'h0000,0,1, 16'h0002,16'h0003,16'h0001,16'h0001,0, 1, EQ_EARLY, 0, 32'h00000000);
        do_op("eq_eq", ALU_OP_EQ,  0, 32'h12345678, 32'h12345678, 16'h0000,0,0, 16'h0000,1,1, 16'h5678,16'h5678,16'h1234,16'h1234,0, 1, 1'b0,     0, 32'h00000001);
        do_op("ltu",   ALU_OP_LTU, 0, 32'h00000001, 32'hFFFFFFFF, 16'h0000,0,0, 16'h0000,1,1, 16'h0001,16'hFFFF,16'h0000,16'hFFFF,0, 1, 1'b0,     5, 32'h00000001);
        do_op("lt_fl", ALU_OP_LT,  1, 32'hFFFFFFFF, 32'h00000000, 16'h0000,0,0, 16'h0000,0,1, 16'hFFFF,16'h0000,16'hFFFF,16'h0000,0, 1, 1'b0,     0, 32'h00000000);

        // Reset in BEAT1 drops the request; in_valid held during reset must not start anything.
        in_op = ALU_OP_ADD; in_cmp_flip = 1'b0; in_a = 32'h00001234; in_b = 32'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_result_i = 16'h1234;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid.b1.busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.ovalid", 32'(out_valid), 32'd0);
        chk("rst_mid.in_ready", 32'(in_ready), 32'd0);
        chk("rst_mid.first", 32'(alu_first_cycle_o), 32'd0);
        chk("rst_mid.result", out_result, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; alu_result_i = 16'h0;
        @(negedge clk);
        chk("rst_rel.in_ready", 32'(in_ready), 32'd1);
        chk("rst_rel.busy", 32'(busy), 32'd0);
        chk("rst_rel.ovalid", 32'(out_valid), 32'd0);

        do_op("sub",   ALU_OP_SUB, 0, 32'h00010000, 32'h00000001, 16'hFFFF,0,0, 16'h0000,0,0, 16'h0000,16'h0001,16'h0001,16'h0000,0, 1, 1'b0,     0, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
